bcd_seg_driver: RTL and testbench

BCD_SEG_DRIVER -- requirements
Module: bcd_seg_driver

---
 rtl/bcd_seg_driver_pkg.sv | 43 ++++
 rtl/bcd_seg_driver_seg7_encode.sv | 29 ++
 rtl/bcd_seg_driver.sv | 120 ++++++++++++
 tb/tb_bcd_seg_driver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_seg_driver_pkg.sv
// rtl/bcd_seg_driver_pkg.sv - shared state encodings, segment patterns and BCD helper
package bcd_seg_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_LATCH   = 2'd2
    } state_e;

    localparam int VALUE_W    = 17;
    localparam int BCD_W      = 20;
    localparam int NUM_DIGITS = 5;

    localparam logic [VALUE_W-1:0] VALUE_MAX  = 17'd99999;
    localparam logic [4:0]         LAST_SHIFT = 5'd16;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift
    function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_seg_driver_seg7_encode.sv
// rtl/bcd_seg_driver_seg7_encode.sv - one BCD digit plus blank flag to active-low segments
module seg7_encode
    import bcd_seg_driver_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_seg_driver.sv
// rtl/bcd_seg_driver.sv - 17-bit binary to five-digit seven-segment driver via double dabble
module bcd_seg_driver
    import bcd_seg_driver_pkg::*;
#(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [VALUE_W-1:0]  value,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [6:0]          seg_first,
    output logic [6:0]          seg_second,
    output logic [6:0]          seg_third,
    output logic [6:0]          seg_fourth,
    output logic [6:0]          seg_fifth
);

    state_e                         state_q, state_d;
    logic [VALUE_W-1:0]             bin_q, bin_d;
    logic [BCD_W-1:0]               bcd_q, bcd_d;
    logic [BCD_W-1:0]               bcd_adj;
    logic [4:0]                     cnt_q, cnt_d;
    logic                           ovf_pend_q, ovf_pend_d;
    logic                           done_q, done_d;
    logic                           overflow_q, overflow_d;
    logic [NUM_DIGITS-1:0][6:0]     seg_q, seg_d, seg_enc;
    logic [NUM_DIGITS-1:0]          blank;
    logic                           lead;

    assign bcd_adj = add3_nibbles(bcd_q);

    // A digit blanks only while every more significant digit is also a leading zero
    always_comb begin
        blank = '0;
        lead  = BLANK_LEADING;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead     = lead && (bcd_q[i*4 +: 4] == 4'd0);
            blank[i] = lead;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
        seg7_encode u_enc (
            .digit (bcd_q[g*4 +: 4]),
            .blank (blank[g]),
            .seg   (seg_enc[g])
        );
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        seg_d      = seg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d      = value;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (value > VALUE_MAX);
                    state_d    = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 5'd1;
                if (cnt_q == LAST_SHIFT) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                done_d     = 1'b1;
                overflow_d = ovf_pend_q;
                seg_d      = ovf_pend_q ? {NUM_DIGITS{SEG_DASH}} : seg_enc;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            seg_q      <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            seg_q      <= seg_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign seg_first  = seg_q[0];
    assign seg_second = seg_q[1];
    assign seg_third  = seg_q[2];
    assign seg_fourth = seg_q[3];
    assign seg_fifth  = seg_q[4];

endmodule

// File: tb/tb_bcd_seg_driver.sv
// tb/tb_bcd_seg_driver.sv - directed self-checking bench for bcd_seg_driver
module tb_bcd_seg_driver;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D8 = 7'b0000000;
    localparam logic [6:0] D9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [16:0] value;
    logic        busy, done, overflow;
    logic [6:0]  s1, s2, s3, s4, s5;
    logic        busy_nb, done_nb, overflow_nb;
    logic [6:0]  n1, n2, n3, n4, n5;
    logic [34:0] segs, segs_nb;

    int n_assert = 0;
    int n_fail   = 0;

    assign segs    = {s5, s4, s3, s2, s1};
    assign segs_nb = {n5, n4, n3, n2, n1};

    bcd_seg_driver #(.BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value),
        .busy(busy), .done(done), .overflow(overflow),
        .seg_first(s1), .seg_second(s2), .seg_third(s3),
        .seg_fourth(s4), .seg_fifth(s5)
    );

    bcd_seg_driver #(.BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value),
        .busy(busy_nb), .done(done_nb), .overflow(overflow_nb),
        .seg_first(n1), .seg_second(n2), .seg_third(n3),
        .seg_fourth(n4), .seg_fifth(n5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; the next edge samples start, value is scrambled afterwards
    task automatic kick(input logic [16:0] v);
        start = 1'b1;
        value = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = 17'd99999;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done !== 1'b1 && n < 40);
    endtask

    int lat, busy_cnt, done_cnt;
    int hits[$];

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        value = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_busy", 35'(busy), 35'd0);
        chk("reset_done", 35'(done), 35'd0);
        chk("reset_ovf", 35'(overflow), 35'd0);
        chk("reset_segs", segs, {5{BL}});
        @(posedge clk);
        @(posedge clk);
        #1;

        rst_n = 1'b1;
        kick(17'd12345);
        chk("12345_busy", 35'(busy), 35'd1);
        wait_done(lat);
        chk("12345_latency", 35'(lat), 35'd18);
        chk("12345_busy_at_done", 35'(busy), 35'd0);
        chk("12345_segs", segs, {D1, D2, D3, D4, D5});
        chk("12345_ovf", 35'(overflow), 35'd0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 35'(done), 35'd0);
        chk("segs_hold", segs, {D1, D2, D3, D4, D5});

        kick(17'd0);
        wait_done(lat);
        chk("zero_latency", 35'(lat), 35'd18);
        chk("zero_blank", segs, {BL, BL, BL, BL, D0});
        chk("zero_noblank", segs_nb, {D0, D0, D0, D0, D0});

        kick(17'd99999);
        wait_done(lat);
        chk("99999_segs", segs, {D9, D9, D9, D9, D9});
        chk("99999_ovf", 35'(overflow), 35'd0);

        kick(17'd100000);
        wait_done(lat);
        chk("100000_segs", segs, {DS, DS, DS, DS, DS});
        chk("100000_ovf", 35'(overflow), 35'd1);

        kick(17'd305);
        wait_done(lat);
        chk("305_segs", segs, {BL, BL, D3, D0, D5});
        chk("305_ovf_cleared", 35'(overflow), 35'd0);
        chk("305_noblank", segs_nb, {D0, D0, D3, D0, D5});

        kick(17'd12345);
        busy_cnt = busy;
        done_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                start = 1'b1;
                value = 17'd54321;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            busy_cnt += busy;
            done_cnt += done;
        end
        chk("ignore_done_count", 35'(done_cnt), 35'd1);
        chk("ignore_busy_cycles", 35'(busy_cnt), 35'd18);
        chk("ignore_segs", segs, {D1, D2, D3, D4, D5});

        kick(17'd777);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_segs", segs, {5{BL}});
        chk("abort_busy", 35'(busy), 35'd0);
        chk("abort_done", 35'(done), 35'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            done_cnt += done;
        end
        chk("abort_no_done", 35'(done_cnt), 35'd0);
        kick(17'd42);
        wait_done(lat);
        chk("42_latency", 35'(lat), 35'd18);
        chk("42_segs", segs, {BL, BL, BL, D4, D2});

        start = 1'b1;
        value = 17'd8;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) hits.push_back(k);
        end
        start = 1'b0;
        chk("b2b_pulses", 35'(hits.size()), 35'd3);
        if (hits.size() == 3) begin
            chk("b2b_first", 35'(hits[0]), 35'd19);
            chk("b2b_gap1", 35'(hits[1] - hits[0]), 35'd19);
            chk("b2b_gap2", 35'(hits[2] - hits[1]), 35'd19);
        end
        repeat (25) @(posedge clk);
        #1;
        chk("b2b_segs", segs, {BL, BL, BL, BL, D8});
        chk("b2b_idle", 35'(busy), 35'd0);

        kick(17'd7);
        wait_done(lat);
        chk("7_noblank", segs_nb, {D0, D0, D0, D0, D7});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
